fb_pattern_writer: RTL and testbench
====================================

# fb_pattern_writer

Parametrised, double-buffered framebuffer pattern writer. Generates one 8-bit palette index per pixel according to a selectable pattern mode, maps it through a 256×24 palette RAM, and writes 32-bit pixels to SDRAM over the single-word `sd_*` request/done handshake. It draws into the back buffer and swaps buffers on the first vsync rising edge after a frame completes. It sits between the SDRAM controller's client port and the video scan-out, which reads `out_fbuffer`.

## Interface
Parameters:
- `WIDTH`, 640, pixels per line (≥1)
- `HEIGHT`, 480, lines per frame (≥1)
- `BASE_ADDR`, 32'h40C00000, byte address of buffer 0
- `BUF_STRIDE`, WIDTH*HEIGHT*4, byte offset of buffer 1 from buffer 0
- `SHIFT_STEP`, 9, per-frame pattern shift increment
- `SHIFT_WRAP`, 639, shift wraps to 0 when shift ≥ SHIFT_WRAP
- `WAIT_CYCLES`, 5, idle cycles after each `in_sd_done`

Ports:
- `clock` in 1: the only clock
- `reset` in 1: synchronous, active-high
- `in_enable` in 1: level; frames start only while high
- `in_mode` in 2: 0 diagonal (x+y+shift), 1 vertical bands (x+shift), 2 horizontal bands (y+shift), 3 solid (shift); index is the low 8 bits
- `in_vsync` in 1: from the video timing generator
- `in_sd_done` in 1: SDRAM write completed
- `in_sd_data_out` in 32: unused (write-only client)
- `in_pal_we` in 1, `in_pal_addr` in 8, `in_pal_wdata` in 24: palette write port
- `out_sd_addr` out 32, `out_sd_data_in` out 32, `out_sd_rw` out 1, `out_sd_in_valid` out 1, `out_sd_wmask` out 4
- `out_fbuffer` out 1: buffer currently displayed
- `out_done` out 1: high in IDLE
- `out_frame_done` out 1: one-cycle pulse on buffer swap

## Operation
- States: IDLE, FRAME_START, PIX_ADDR, PIX_ISSUE, WAIT_DONE, GAP, FRAME_END, WAIT_VSYNC.
- **IDLE:** if `in_enable` is high → FRAME_START.
- **FRAME_START:**
  - latch `in_mode`; x=0, y=0
  - pointer = BASE_ADDR + (~fbuffer ? BUF_STRIDE : 0)
- **PIX_ADDR:** compute palette index, drive palette read address → PIX_ISSUE.
- **PIX_ISSUE:**
  - register `out_sd_addr` = pointer and `out_sd_data_in` = {8'h00, rdata}
  - pulse `out_sd_in_valid` for exactly one cycle → WAIT_DONE
- **WAIT_DONE:**
  - hold addr/data stable
  - on `in_sd_done`=1: load the gap counter with WAIT_CYCLES → GAP
- **GAP:**
  - decrement the counter to 0
  - then pointer += 4 and x++
  - if x wraps at WIDTH: x=0, y++
  - if y reaches HEIGHT → FRAME_END, else → PIX_ADDR
- **FRAME_END:** → WAIT_VSYNC.
- **WAIT_VSYNC:** on a vsync rising edge:
  - toggle fbuffer and pulse `out_frame_done`
  - shift = (shift ≥ SHIFT_WRAP) ? 0 : shift + SHIFT_STEP
  - → FRAME_START if `in_enable`, else IDLE
- **Vsync detection:** `in_vsync` passes through one register stage, and the edge is detected against a second register. Only edges seen while in WAIT_VSYNC count; earlier edges are discarded.
- **Arithmetic:**
  - shift is 16 bits, x is clog2(WIDTH)+1 bits, y is clog2(HEIGHT)+1 bits
  - the index sum is computed at 16 bits and truncated to 8
  - the address uses 32-bit modular addition with no multipliers
- **Constant outputs:** `out_sd_rw`=1 and `out_sd_wmask`=4'b1111 at all times.
- **Palette writes:**
  - accepted in any state; take effect on the next edge
  - a read of the same address in the same cycle returns the old data
  - initial contents: entry i = {i,i,i}
- **`in_enable` low mid-frame:** the frame completes; the block parks in IDLE after the swap.

## Timing
- Reset values:
  - `out_sd_addr`=0, `out_sd_data_in`=0, `out_sd_in_valid`=0, `out_sd_rw`=1, `out_sd_wmask`=4'b1111
  - `out_fbuffer`=0, `out_frame_done`=0, `out_done`=1 (IDLE)
  - shift=0
- Reset mid-write: `out_sd_in_valid` is 0 on the next edge and any pending request is abandoned. The palette contents are not reset.
- Palette read latency is 1 cycle (address in PIX_ADDR, data used in PIX_ISSUE).
- Per-pixel cost is 3 + WAIT_CYCLES + (done latency − 1) cycles. Minimum is 8 with defaults and done asserted on the first WAIT_DONE cycle.
- `in_sd_done` is ignored outside WAIT_DONE.
- Vsync edge to `out_fbuffer` change is 3 cycles.
- When `in_enable` rises in IDLE, the first `out_sd_in_valid` appears 4 cycles later.

## Structure
- Package `fb_pkg`:
  - state enum
  - mode constants MODE_DIAG/MODE_VBAND/MODE_HBAND/MODE_SOLID
  - BYTES_PER_PIXEL=4, PAL_DEPTH=256, PAL_WIDTH=24
- Sub-module `fb_palette_ram`: 256×24, one registered read port and one write port, same clock, initial ramp.

## Test plan
- **Single frame, default ramp:** WIDTH=4, HEIGHT=2, mode 0, done returned 2 cycles after valid.
  - Expect 8 writes at addresses BASE_ADDR+BUF_STRIDE+0x0…0x1C, in order.
  - Expect data 0x000000,0x010101,0x020202,0x030303,0x010101,…,0x040404.
- **Swap:** frame completes, then vsync rises 100 cycles later.
  - `out_fbuffer` goes 0→1 three cycles after the edge, and `out_frame_done` pulses once.
  - The next frame writes at BASE_ADDR+0.
  - A vsync edge that occurs mid-frame causes no swap.
- **Shift wrap:** SHIFT_STEP=9, SHIFT_WRAP=20 → shifts over successive frames are 0, 9, 18, 27, 0. Mode 3 pixel data is 0x000000, 0x090909, 0x121212, 0x1B1B1B, 0x000000.
- **Palette write in flight:** write entry 5 = 0xABCDEF, then run mode 3 with shift=5 → every pixel is 0x00ABCDEF. A write in the same cycle as the read returns the old value.
- **Handshake stall:** withhold `in_sd_done` for 50 cycles.
  - `out_sd_in_valid` is high for exactly 1 cycle, and addr/data stay stable throughout.
  - Exactly WAIT_CYCLES=5 gap cycles follow done.
- **Reset mid-write:** assert `reset` in WAIT_DONE.
  - All outputs return to their reset values on the next edge and `out_done`=1.
  - A new frame starts at x=0, y=0 into buffer 1.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer pattern writer.
package fb_pkg;

    localparam int unsigned BYTES_PER_PIXEL = 4;
    localparam int unsigned PAL_DEPTH       = 256;
    localparam int unsigned PAL_WIDTH       = 24;
    localparam int unsigned PAL_AW          = 8;

    localparam logic [1:0] MODE_DIAG  = 2'd0;
    localparam logic [1:0] MODE_VBAND = 2'd1;
    localparam logic [1:0] MODE_HBAND = 2'd2;
    localparam logic [1:0] MODE_SOLID = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME_START,
        ST_PIX_ADDR,
        ST_PIX_ISSUE,
        ST_WAIT_DONE,
        ST_GAP,
        ST_FRAME_END,
        ST_WAIT_VSYNC
    } state_t;

    // Palette index: 16-bit pattern sum truncated to the low byte.
    function automatic logic [PAL_AW-1:0] pal_index(input logic [1:0]  mode,
                                                    input logic [15:0] x,
                                                    input logic [15:0] y,
                                                    input logic [15:0] shift);
        case (mode)
            MODE_DIAG:  return PAL_AW'(x + y + shift);
            MODE_VBAND: return PAL_AW'(x + shift);
            MODE_HBAND: return PAL_AW'(y + shift);
            default:    return PAL_AW'(shift);
        endcase
    endfunction

endpackage

// File: rtl/fb_palette_ram.sv
// 256x24 palette: one registered read port, one write port, grey-ramp power-up contents.
module fb_palette_ram
    import fb_pkg::*;
(
    input  logic                 clock,
    input  logic                 we,
    input  logic [PAL_AW-1:0]    waddr,
    input  logic [PAL_WIDTH-1:0] wdata,
    input  logic [PAL_AW-1:0]    raddr,
    output logic [PAL_WIDTH-1:0] rdata
);

    logic [PAL_WIDTH-1:0] mem [PAL_DEPTH];
    // Entries never written read back as the ramp {i,i,i}; survives reset.
    logic [PAL_DEPTH-1:0] written = '0;

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr]     <= wdata;
            written[waddr] <= 1'b1;
        end
        rdata <= written[raddr] ? mem[raddr] : {raddr, raddr, raddr};
    end

endmodule

// File: rtl/fb_pattern_writer.sv
// Double-buffered pattern writer: palette-mapped pixels to SDRAM, buffer swap on vsync.
module fb_pattern_writer
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter logic [31:0] BASE_ADDR   = 32'h40C0_0000,
    parameter logic [31:0] BUF_STRIDE  = 32'(WIDTH * HEIGHT * BYTES_PER_PIXEL),
    parameter int unsigned SHIFT_STEP  = 9,
    parameter int unsigned SHIFT_WRAP  = 639,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_enable,
    input  logic [1:0]           in_mode,
    input  logic                 in_vsync,
    input  logic                 in_sd_done,
    input  logic [31:0]          in_sd_data_out,
    input  logic                 in_pal_we,
    input  logic [PAL_AW-1:0]    in_pal_addr,
    input  logic [PAL_WIDTH-1:0] in_pal_wdata,
    output logic [31:0]          out_sd_addr,
    output logic [31:0]          out_sd_data_in,
    output logic                 out_sd_rw,
    output logic                 out_sd_in_valid,
    output logic [3:0]           out_sd_wmask,
    output logic                 out_fbuffer,
    output logic                 out_done,
    output logic                 out_frame_done
);

    localparam int unsigned XW = $clog2(WIDTH) + 1;
    localparam int unsigned YW = $clog2(HEIGHT) + 1;
    localparam int unsigned CW = $clog2(WAIT_CYCLES + 1) + 1;

    state_t                state;
    logic [1:0]            mode_q;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [31:0]           ptr;
    logic [CW-1:0]         gap_cnt;
    logic [15:0]           shift;
    logic                  vs_q1, vs_q2, vs_rise;
    logic [PAL_AW-1:0]     pal_raddr;
    logic [PAL_WIDTH-1:0]  pal_rdata;
    logic                  unused_sd_data;

    assign out_sd_rw      = 1'b1;
    assign out_sd_wmask   = 4'b1111;
    assign unused_sd_data = ^in_sd_data_out;
    assign pal_raddr      = pal_index(mode_q, 16'(x), 16'(y), shift);

    fb_palette_ram u_palette (
        .clock (clock),
        .we    (in_pal_we),
        .waddr (in_pal_addr),
        .wdata (in_pal_wdata),
        .raddr (pal_raddr),
        .rdata (pal_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            mode_q          <= MODE_DIAG;
            x               <= '0;
            y               <= '0;
            ptr             <= '0;
            gap_cnt         <= '0;
            shift           <= '0;
            vs_q1           <= 1'b0;
            vs_q2           <= 1'b0;
            vs_rise         <= 1'b0;
            out_sd_addr     <= '0;
            out_sd_data_in  <= '0;
            out_sd_in_valid <= 1'b0;
            out_fbuffer     <= 1'b0;
            out_done        <= 1'b1;
            out_frame_done  <= 1'b0;
        end else begin
            // Sync stage, edge reference, then a registered rise pulse.
            vs_q1           <= in_vsync;
            vs_q2           <= vs_q1;
            vs_rise         <= vs_q1 & ~vs_q2;
            out_sd_in_valid <= 1'b0;
            out_frame_done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (in_enable) begin
                        state    <= ST_FRAME_START;
                        out_done <= 1'b0;
                    end
                end
                ST_FRAME_START: begin
                    mode_q <= in_mode;
                    x      <= '0;
                    y      <= '0;
                    ptr    <= BASE_ADDR + (out_fbuffer ? 32'd0 : BUF_STRIDE);
                    state  <= ST_PIX_ADDR;
                end
                ST_PIX_ADDR: begin
                    state <= ST_PIX_ISSUE;
                end
                ST_PIX_ISSUE: begin
                    out_sd_addr     <= ptr;
                    out_sd_data_in  <= {8'h00, pal_rdata};
                    out_sd_in_valid <= 1'b1;
                    state           <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (in_sd_done) begin
                        gap_cnt <= CW'(WAIT_CYCLES);
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt < CW'(2)) begin
                        ptr <= ptr + 32'(BYTES_PER_PIXEL);
                        if (x == XW'(WIDTH - 1)) begin
                            x     <= '0;
                            y     <= y + YW'(1);
                            state <= (y == YW'(HEIGHT - 1)) ? ST_FRAME_END : ST_PIX_ADDR;
                        end else begin
                            x     <= x + XW'(1);
                            state <= ST_PIX_ADDR;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - CW'(1);
                    end
                end
                ST_FRAME_END: begin
                    state <= ST_WAIT_VSYNC;
                end
                ST_WAIT_VSYNC: begin
                    if (vs_rise) begin
                        out_fbuffer    <= ~out_fbuffer;
                        out_frame_done <= 1'b1;
                        shift          <= (shift >= 16'(SHIFT_WRAP)) ? 16'd0
                                                                     : shift + 16'(SHIFT_STEP);
                        if (in_enable) begin
                            state <= ST_FRAME_START;
                        end else begin
                            state    <= ST_IDLE;
                            out_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    out_done <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Directed bench for fb_pattern_writer on a 4x2 frame with a small shift wrap.
module tb_fb_pattern_writer;

    localparam logic [31:0] BASE = 32'h40C0_0000;
    localparam logic [31:0] BUF1 = 32'h40C0_0020;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_enable;
    logic [1:0]  in_mode;
    logic        in_vsync;
    logic        in_sd_done;
    logic [31:0] in_sd_data_out;
    logic        in_pal_we;
    logic [7:0]  in_pal_addr;
    logic [23:0] in_pal_wdata;
    logic [31:0] out_sd_addr;
    logic [31:0] out_sd_data_in;
    logic        out_sd_rw;
    logic        out_sd_in_valid;
    logic [3:0]  out_sd_wmask;
    logic        out_fbuffer;
    logic        out_done;
    logic        out_frame_done;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clock = ~clock;

    fb_pattern_writer #(
        .WIDTH       (4),
        .HEIGHT      (2),
        .BASE_ADDR   (BASE),
        .BUF_STRIDE  (32'h20),
        .SHIFT_STEP  (9),
        .SHIFT_WRAP  (20),
        .WAIT_CYCLES (5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_enable       (in_enable),
        .in_mode         (in_mode),
        .in_vsync        (in_vsync),
        .in_sd_done      (in_sd_done),
        .in_sd_data_out  (in_sd_data_out),
        .in_pal_we       (in_pal_we),
        .in_pal_addr     (in_pal_addr),
        .in_pal_wdata    (in_pal_wdata),
        .out_sd_addr     (out_sd_addr),
        .out_sd_data_in  (out_sd_data_in),
        .out_sd_rw       (out_sd_rw),
        .out_sd_in_valid (out_sd_in_valid),
        .out_sd_wmask    (out_sd_wmask),
        .out_fbuffer     (out_fbuffer),
        .out_done        (out_done),
        .out_frame_done  (out_frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns the number of falling edges until a request is visible.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (out_sd_in_valid !== 1'b1 && cnt < 300);
        check("valid_seen", 32'(out_sd_in_valid), 32'd1);
    endtask

    // Called on the cycle a request is visible; acks it after lat cycles.
    task automatic serve(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input int lat);
        check({tag, "_addr"}, out_sd_addr, a);
        check({tag, "_data"}, out_sd_data_in, d);
        for (int k = 1; k < lat; k++) begin
            @(negedge clock);
            check({tag, "_stall_valid"}, 32'(out_sd_in_valid), 32'd0);
            check({tag, "_stall_addr"}, out_sd_addr, a);
            check({tag, "_stall_data"}, out_sd_data_in, d);
        end
        in_sd_done = 1'b1;
        @(negedge clock);
        in_sd_done = 1'b0;
        check({tag, "_valid_pulse"}, 32'(out_sd_in_valid), 32'd0);
    endtask

    task automatic run_solid(input string tag, input logic [31:0] base, input logic [23:0] d);
        int cnt;
        for (int i = 0; i < 8; i++) begin
            wait_valid(cnt);
            serve(tag, base + 32'(4 * i), {8'h00, d}, 1);
        end
    endtask

    task automatic do_swap(input int cyc, input logic exp_fb);
        repeat (cyc) @(negedge clock);
        check("pre_swap_fb", 32'(out_fbuffer), 32'(!exp_fb));
        check("pre_swap_valid", 32'(out_sd_in_valid), 32'd0);
        check("pre_swap_done", 32'(out_done), 32'd0);
        in_vsync = 1'b1;
        @(negedge clock);
        check("swap_lat1_fb", 32'(out_fbuffer), 32'(!exp_fb));
        @(negedge clock);
        check("swap_lat2_fb", 32'(out_fbuffer), 32'(!exp_fb));
        @(negedge clock);
        check("swap_lat3_fb", 32'(out_fbuffer), 32'(exp_fb));
        check("swap_frame_done", 32'(out_frame_done), 32'd1);
        @(negedge clock);
        check("swap_frame_done_end", 32'(out_frame_done), 32'd0);
        in_vsync = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, out_sd_addr, 32'd0);
        check({tag, "_data"}, out_sd_data_in, 32'd0);
        check({tag, "_valid"}, 32'(out_sd_in_valid), 32'd0);
        check({tag, "_rw"}, 32'(out_sd_rw), 32'd1);
        check({tag, "_wmask"}, 32'(out_sd_wmask), 32'hF);
        check({tag, "_fb"}, 32'(out_fbuffer), 32'd0);
        check({tag, "_frame_done"}, 32'(out_frame_done), 32'd0);
        check({tag, "_done"}, 32'(out_done), 32'd1);
    endtask

    initial begin
        logic [7:0] idx;
        reset          = 1'b1;
        in_enable      = 1'b0;
        in_mode        = 2'd0;
        in_vsync       = 1'b0;
        in_sd_done     = 1'b0;
        in_sd_data_out = 32'h0;
        in_pal_we      = 1'b0;
        in_pal_addr    = 8'd0;
        in_pal_wdata   = 24'd0;
        repeat (3) @(negedge clock);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clock);
        check("idle_done", 32'(out_done), 32'd1);

        // Frame 1: diagonal ramp into buffer 1, one long stall, a mid-frame vsync.
        in_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_valid(n);
            check(i == 0 ? "enable_latency" : "gap_to_valid", 32'(n), i == 0 ? 32'd4 : 32'd7);
            if (i == 3) in_vsync = 1'b1;
            if (i == 5) in_vsync = 1'b0;
            idx = 8'((i % 4) + (i / 4));
            serve("f1", BUF1 + 32'(4 * i), {8'h00, idx, idx, idx}, i == 1 ? 51 : 2);
        end

        in_mode = 2'd3;
        @(negedge clock);
        in_pal_we    = 1'b1;
        in_pal_addr  = 8'd18;
        in_pal_wdata = 24'hABCDEF;
        @(negedge clock);
        in_pal_we = 1'b0;
        do_swap(100, 1'b1);

        // Frame 2: solid, shift 9, buffer 0.
        run_solid("f2", BASE, 24'h090909);
        do_swap(20, 1'b0);

        // Frame 3: shift 18 hits the rewritten entry; a write coincident with the read.
        wait_valid(n);
        serve("f3_p0", BUF1, 32'h00ABCDEF, 1);
        repeat (5) @(negedge clock);
        in_pal_we    = 1'b1;
        in_pal_addr  = 8'd18;
        in_pal_wdata = 24'h123456;
        @(negedge clock);
        in_pal_we = 1'b0;
        wait_valid(n);
        check("pal_coincident_timing", 32'(n), 32'd1);
        serve("f3_same_cycle", BUF1 + 32'd4, 32'h00ABCDEF, 1);
        for (int i = 2; i < 8; i++) begin
            wait_valid(n);
            serve("f3_new", BUF1 + 32'(4 * i), 32'h00123456, 1);
        end
        do_swap(20, 1'b1);

        // Frame 4: shift 27, then frame 5 wraps to 0 with enable dropped mid-frame.
        run_solid("f4", BASE, 24'h1B1B1B);
        do_swap(20, 1'b0);
        in_enable = 1'b0;
        run_solid("f5", BUF1, 24'h000000);
        do_swap(20, 1'b1);
        check("parked_done", 32'(out_done), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("parked_valid", 32'(out_sd_in_valid), 32'd0);
        end

        // Frame 6 starts in buffer 0 with shift 9; reset hits while waiting for done.
        in_mode   = 2'd0;
        in_enable = 1'b1;
        wait_valid(n);
        check("restart_latency", 32'(n), 32'd4);
        check("f6_addr", out_sd_addr, BASE);
        check("f6_data", out_sd_data_in, 32'h00090909);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("midwrite");
        reset = 1'b0;
        wait_valid(n);
        check("post_reset_latency", 32'(n), 32'd4);
        serve("post_reset_p0", BUF1, 32'h00000000, 1);
        wait_valid(n);
        check("post_reset_gap", 32'(n), 32'd7);
        serve("post_reset_p1", BUF1 + 32'd4, 32'h00010101, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
